// File: rtl/axi_mux_pkg.sv
// Shared types for the N:1 AXI4 multiplexer.
// Holds FSM state enums, AXI burst/resp encodings and the AX control struct.
package axi_mux_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_ADDR,
        R_DATA
    } r_state_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_ADDR,
        W_DATA,
        W_RESP
    } w_state_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    // Width-independent part of an AR/AW request. The top wraps it together
    // with its ID_W/ADDR_W-sized id and address into ax_req_t.
    typedef struct packed {
        logic [7:0] len;
        logic [2:0] size;
        logic [1:0] burst;
    } ax_ctl_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr.
// Ports: req (N requests), accept (commit grant), grant (one-hot), grant_idx.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
    input  logic          accept,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [PW-1:0] ptr;

    always_comb begin : p_pick
        logic [PW:0] s;
        logic        hit;
        s         = '0;
        hit       = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            // (ptr + i) mod N without a divider
            s = {1'b0, ptr} + (PW+1)'(i);
            if (s >= (PW+1)'(N)) s = s - (PW+1)'(N);
            if (!hit && req[s[PW-1:0]]) begin
                hit                = 1'b1;
                grant[s[PW-1:0]]   = 1'b1;
                grant_idx          = s[PW-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept && |req) begin
            ptr <= (grant_idx == PW'(N-1)) ? '0 : grant_idx + PW'(1);
        end
    end

endmodule

// File: rtl/axi_mux_nto1.sv
// N:1 AXI4 mux: independent round-robin read and write paths, one txn each.
// Ports: s_* per-master AR/R/AW/W/B arrays, m_* single downstream, wdt_err.
// Build option AXI_MUX_WDT_EN adds stall watchdogs; otherwise wdt_err = 0.
module axi_mux_nto1
    import axi_mux_pkg::*;
#(
    parameter int N_MST     = 2,
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int WDT_LIMIT = 1024
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_MST-1:0]    s_arvalid,
    output logic [N_MST-1:0]    s_arready,
    input  logic [ID_W-1:0]     s_arid    [N_MST],
    input  logic [ADDR_W-1:0]   s_araddr  [N_MST],
    input  logic [7:0]          s_arlen   [N_MST],
    input  logic [2:0]          s_arsize  [N_MST],
    input  logic [1:0]          s_arburst [N_MST],
    output logic [N_MST-1:0]    s_rvalid,
    input  logic [N_MST-1:0]    s_rready,
    output logic [ID_W-1:0]     s_rid     [N_MST],
    output logic [DATA_W-1:0]   s_rdata   [N_MST],
    output logic [1:0]          s_rresp   [N_MST],
    output logic [N_MST-1:0]    s_rlast,
    input  logic [N_MST-1:0]    s_awvalid,
    output logic [N_MST-1:0]    s_awready,
    input  logic [ID_W-1:0]     s_awid    [N_MST],
    input  logic [ADDR_W-1:0]   s_awaddr  [N_MST],
    input  logic [7:0]          s_awlen   [N_MST],
    input  logic [2:0]          s_awsize  [N_MST],
    input  logic [1:0]          s_awburst [N_MST],
    input  logic [N_MST-1:0]    s_wvalid,
    output logic [N_MST-1:0]    s_wready,
    input  logic [DATA_W-1:0]   s_wdata   [N_MST],
    input  logic [DATA_W/8-1:0] s_wstrb   [N_MST],
    input  logic [N_MST-1:0]    s_wlast,
    output logic [N_MST-1:0]    s_bvalid,
    input  logic [N_MST-1:0]    s_bready,
    output logic [ID_W-1:0]     s_bid     [N_MST],
    output logic [1:0]          s_bresp   [N_MST],
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ID_W-1:0]     m_arid,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rlast,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [ID_W-1:0]     m_awid,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic [7:0]          m_awlen,
    output logic [2:0]          m_awsize,
    output logic [1:0]          m_awburst,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wlast,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [ID_W-1:0]     m_bid,
    input  logic [1:0]          m_bresp,
    output logic                wdt_err
);

    localparam int PW = $clog2(N_MST);

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        ax_ctl_t           ctl;
    } ax_req_t;

    if (WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_bad_limit
        $error("axi_mux_nto1: WDT_LIMIT must fit the 16-bit counter");
    end

    r_state_e r_state, r_next;
    w_state_e w_state, w_next;
    logic [PW-1:0] r_sel, w_sel, ar_idx, aw_idx;
    logic [N_MST-1:0] ar_grant, aw_grant;
    logic ar_take, aw_take;
    ax_req_t ar_q, aw_q;

    assign ar_take = (r_state == R_IDLE) && |s_arvalid;
    assign aw_take = (w_state == W_IDLE) && |s_awvalid;

    rr_arbiter #(.N(N_MST)) u_ar_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (s_arvalid),
        .accept    (ar_take),
        .grant     (ar_grant),
        .grant_idx (ar_idx)
    );

    rr_arbiter #(.N(N_MST)) u_aw_arb (
        .clock     (clock),
        .reset     (reset),
        .req       (s_awvalid),
        .accept    (aw_take),
        .grant     (aw_grant),
        .grant_idx (aw_idx)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= R_IDLE;
            w_state <= W_IDLE;
            r_sel   <= '0;
            w_sel   <= '0;
            ar_q    <= '0;
            aw_q    <= '0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            if (ar_take) begin
                r_sel          <= ar_idx;
                ar_q.id        <= s_arid[ar_idx];
                ar_q.addr      <= s_araddr[ar_idx];
                ar_q.ctl.len   <= s_arlen[ar_idx];
                ar_q.ctl.size  <= s_arsize[ar_idx];
                ar_q.ctl.burst <= s_arburst[ar_idx];
            end
            if (aw_take) begin
                w_sel          <= aw_idx;
                aw_q.id        <= s_awid[aw_idx];
                aw_q.addr      <= s_awaddr[aw_idx];
                aw_q.ctl.len   <= s_awlen[aw_idx];
                aw_q.ctl.size  <= s_awsize[aw_idx];
                aw_q.ctl.burst <= s_awburst[aw_idx];
            end
        end
    end

    always_comb begin
        r_next    = r_state;
        s_arready = '0;
        s_rvalid  = '0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        unique case (r_state)
            R_IDLE: if (ar_take) begin
                s_arready = ar_grant;
                r_next    = R_ADDR;
            end
            R_ADDR: begin
                m_arvalid = 1'b1;
                if (m_arready) r_next = R_DATA;
            end
            R_DATA: begin
                s_rvalid[r_sel] = m_rvalid;
                m_rready        = s_rready[r_sel];
                if (m_rvalid && m_rready && m_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_next    = w_state;
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        unique case (w_state)
            W_IDLE: if (aw_take) begin
                s_awready = aw_grant;
                w_next    = W_ADDR;
            end
            W_ADDR: begin
                m_awvalid = 1'b1;
                if (m_awready) w_next = W_DATA;
            end
            W_DATA: begin
                m_wvalid        = s_wvalid[w_sel];
                s_wready[w_sel] = m_wready;
                if (m_wvalid && m_wready && m_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_bvalid[w_sel] = m_bvalid;
                m_bready        = s_bready[w_sel];
                if (m_bvalid && m_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    // Payloads fan out to every master; only the valid is steered.
    always_comb begin
        for (int i = 0; i < N_MST; i++) begin
            s_rid[i]   = m_rid;
            s_rdata[i] = m_rdata;
            s_rresp[i] = m_rresp;
            s_rlast[i] = m_rlast;
            s_bid[i]   = m_bid;
            s_bresp[i] = m_bresp;
        end
    end

    assign m_arid    = ar_q.id;
    assign m_araddr  = ar_q.addr;
    assign m_arlen   = ar_q.ctl.len;
    assign m_arsize  = ar_q.ctl.size;
    assign m_arburst = ar_q.ctl.burst;
    assign m_awid    = aw_q.id;
    assign m_awaddr  = aw_q.addr;
    assign m_awlen   = aw_q.ctl.len;
    assign m_awsize  = aw_q.ctl.size;
    assign m_awburst = aw_q.ctl.burst;
    assign m_wdata   = s_wdata[w_sel];
    assign m_wstrb   = s_wstrb[w_sel];
    assign m_wlast   = s_wlast[w_sel];

`ifdef AXI_MUX_WDT_EN
    logic [15:0] r_cnt, w_cnt;
    logic r_hs, w_hs, r_trip, w_trip;

    assign r_hs = (m_arvalid && m_arready) || (m_rvalid && m_rready);
    assign w_hs = (m_awvalid && m_awready) || (m_wvalid && m_wready)
               || (m_bvalid && m_bready);

    // Trip on the edge where the count would reach the limit.
    assign r_trip = (r_state != R_IDLE) && !r_hs
                 && (int'(r_cnt) + 1 >= WDT_LIMIT);
    assign w_trip = (w_state != W_IDLE) && !w_hs
                 && (int'(w_cnt) + 1 >= WDT_LIMIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            w_cnt   <= '0;
            wdt_err <= 1'b0;
        end else begin
            if (r_state == R_IDLE || r_hs) r_cnt <= '0;
            else if (r_cnt != 16'hFFFF)    r_cnt <= r_cnt + 16'd1;
            if (w_state == W_IDLE || w_hs) w_cnt <= '0;
            else if (w_cnt != 16'hFFFF)    w_cnt <= w_cnt + 16'd1;
            if (r_trip || w_trip) wdt_err <= 1'b1;
        end
    end
`else
    assign wdt_err = 1'b0;
`endif

endmodule
